fsm_error_monitor: RTL and testbench

Downstream consumer of the lane FSM comparator's error outputs. The comparator's `error_state` and `error_mismatch` flags drive this block. It accumulates saturating event counters, timestamps the first error relative to enable, and keeps sticky flags. It also exposes a latch/clear handshake so slow-control logic can read a coherent snapshot without stopping the lane.

---
 rtl/fsm_error_monitor.sv | 150 +++++++++++++++
 tb/tb_fsm_error_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_error_monitor.sv
// fsm_error_monitor
// Watches the lane FSM comparator's error flags. It keeps saturating event
// counters, the enable-relative timestamp of the first error, and sticky
// flags. A latch/clear handshake lets slow control read a coherent snapshot
// while the lane keeps running.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   enable_i              counting enable (level)
//   error_state_i         comparator FSM-in-error flag (level)
//   error_mismatch_i      comparator mismatch flag (level)
//   latch_i               snapshot request (pulse)
//   clear_i               clear live counters/timestamp/sticky flags (pulse)
//   mismatch_count_o      snapshot: enabled cycles with mismatch
//   state_error_count_o   snapshot: enabled rising edges of error_state_i
//   first_error_cycle_o   snapshot: timestamp of first error event
//   snapshot_valid_o      one-cycle pulse when the snapshot updates
//   error_seen_o          live sticky: any error event since clear/reset
//   overflow_o            live sticky: a counter or the timestamp saturated
//   state_o               live FSM state: 0 DISABLED, 1 ARMED, 2 ERRORED
module fsm_error_monitor #(
  parameter int CNT_WIDTH_G = 16,
  parameter int TS_WIDTH_G  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   error_state_i,
  input  logic                   error_mismatch_i,
  input  logic                   latch_i,
  input  logic                   clear_i,
  output logic [CNT_WIDTH_G-1:0] mismatch_count_o,
  output logic [CNT_WIDTH_G-1:0] state_error_count_o,
  output logic [TS_WIDTH_G-1:0]  first_error_cycle_o,
  output logic                   snapshot_valid_o,
  output logic                   error_seen_o,
  output logic                   overflow_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ERRORED  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH_G-1:0] CNT_ONE = 1;
  localparam logic [TS_WIDTH_G-1:0]  TS_ONE  = 1;

  state_t                 r_state;
  logic                   r_prev_state;
  logic [CNT_WIDTH_G-1:0] r_mm_cnt;
  logic [CNT_WIDTH_G-1:0] r_se_cnt;
  logic [TS_WIDTH_G-1:0]  r_ts;
  logic [TS_WIDTH_G-1:0]  r_first_err;
  logic                   r_seen;
  logic                   r_ovf;
  logic [CNT_WIDTH_G-1:0] r_snap_mm;
  logic [CNT_WIDTH_G-1:0] r_snap_se;
  logic [TS_WIDTH_G-1:0]  r_snap_fe;
  logic                   r_snap_vld;

  logic                   w_rise;
  logic                   w_ev_mm;
  logic                   w_ev_se;
  logic                   w_event;
  logic [CNT_WIDTH_G-1:0] w_mm_nxt;
  logic [CNT_WIDTH_G-1:0] w_se_nxt;
  logic [TS_WIDTH_G-1:0]  w_ts_cur;
  logic [TS_WIDTH_G-1:0]  w_ts_nxt;
  logic [TS_WIDTH_G-1:0]  w_fe_nxt;
  logic                   w_seen_nxt;
  logic                   w_ovf_nxt;

  assign w_rise  = error_state_i & ~r_prev_state;
  assign w_ev_mm = enable_i & error_mismatch_i;
  assign w_ev_se = enable_i & w_rise;
  assign w_event = w_ev_mm | w_ev_se;

  // The first enabled cycle after leaving DISABLED reads as timestamp 0,
  // so the restart is folded into the current value rather than a reset.
  assign w_ts_cur = (r_state == ST_DISABLED) ? '0 : r_ts;

  // Pre-clear next values; the snapshot takes these so a latch sees the
  // event of its own cycle even when a clear lands alongside it.
  assign w_mm_nxt   = (w_ev_mm && !(&r_mm_cnt)) ? r_mm_cnt + CNT_ONE : r_mm_cnt;
  assign w_se_nxt   = (w_ev_se && !(&r_se_cnt)) ? r_se_cnt + CNT_ONE : r_se_cnt;
  assign w_ts_nxt   = !enable_i ? r_ts :
                      (&w_ts_cur) ? w_ts_cur : w_ts_cur + TS_ONE;
  assign w_fe_nxt   = (w_event && !r_seen) ? w_ts_cur : r_first_err;
  assign w_seen_nxt = r_seen | w_event;
  assign w_ovf_nxt  = r_ovf | (w_ev_mm & (&r_mm_cnt)) |
                      (w_ev_se & (&r_se_cnt)) | (enable_i & (&w_ts_cur));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_DISABLED;
      r_prev_state <= 1'b0;
      r_mm_cnt     <= '0;
      r_se_cnt     <= '0;
      r_ts         <= '0;
      r_first_err  <= '0;
      r_seen       <= 1'b0;
      r_ovf        <= 1'b0;
      r_snap_mm    <= '0;
      r_snap_se    <= '0;
      r_snap_fe    <= '0;
      r_snap_vld   <= 1'b0;
    end else begin
      // Edge history tracks the input even while disabled, so a level
      // already high at enable does not count as a new edge.
      r_prev_state <= error_state_i;
      r_snap_vld   <= latch_i;
      if (latch_i) begin
        r_snap_mm <= w_mm_nxt;
        r_snap_se <= w_se_nxt;
        r_snap_fe <= w_fe_nxt;
      end
      if (clear_i) begin
        r_mm_cnt    <= '0;
        r_se_cnt    <= '0;
        r_ts        <= '0;
        r_first_err <= '0;
        r_seen      <= 1'b0;
        r_ovf       <= 1'b0;
        r_state     <= enable_i ? ST_ARMED : ST_DISABLED;
      end else begin
        r_mm_cnt    <= w_mm_nxt;
        r_se_cnt    <= w_se_nxt;
        r_ts        <= w_ts_nxt;
        r_first_err <= w_fe_nxt;
        r_seen      <= w_seen_nxt;
        r_ovf       <= w_ovf_nxt;
        // Re-enable lands in ERRORED when errors are still on record.
        if (!enable_i)      r_state <= ST_DISABLED;
        else if (w_seen_nxt) r_state <= ST_ERRORED;
        else                r_state <= ST_ARMED;
      end
    end
  end

  assign mismatch_count_o    = r_snap_mm;
  assign state_error_count_o = r_snap_se;
  assign first_error_cycle_o = r_snap_fe;
  assign snapshot_valid_o    = r_snap_vld;
  assign error_seen_o        = r_seen;
  assign overflow_o          = r_ovf;
  assign state_o             = r_state;

endmodule

// File: tb/tb_fsm_error_monitor.sv
// Directed bench for fsm_error_monitor. Two instances share stimulus: one at
// default widths and one with 4-bit counters to reach saturation. Expected
// snapshots are queued when latch is driven and popped when valid pulses.
module tb_fsm_error_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, err_state = 1'b0, err_mm = 1'b0, latch = 1'b0, clear = 1'b0;

  logic [15:0] m_mm, m_se;
  logic [31:0] m_fe;
  logic        m_vld, m_seen, m_ovf;
  logic [1:0]  m_st;
  logic [3:0]  s_mm, s_se;
  logic [31:0] s_fe;
  logic        s_vld, s_seen, s_ovf;
  logic [1:0]  s_st;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mm_m;
    int mm_s;
    int se;
    int fe;
  } snap_t;
  snap_t q[$];

  always #5 clk = ~clk;

  fsm_error_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .error_state_i(err_state),
    .error_mismatch_i(err_mm), .latch_i(latch), .clear_i(clear),
    .mismatch_count_o(m_mm), .state_error_count_o(m_se),
    .first_error_cycle_o(m_fe), .snapshot_valid_o(m_vld),
    .error_seen_o(m_seen), .overflow_o(m_ovf), .state_o(m_st)
  );

  fsm_error_monitor #(.CNT_WIDTH_G(4)) u_small (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .error_state_i(err_state),
    .error_mismatch_i(err_mm), .latch_i(latch), .clear_i(clear),
    .mismatch_count_o(s_mm), .state_error_count_o(s_se),
    .first_error_cycle_o(s_fe), .snapshot_valid_o(s_vld),
    .error_seen_o(s_seen), .overflow_o(s_ovf), .state_o(s_st)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_snap(input int mm_m, input int mm_s, input int se, input int fe);
    snap_t e;
    e.mm_m = mm_m; e.mm_s = mm_s; e.se = se; e.fe = fe;
    q.push_back(e);
  endtask

  // Drive one cycle, sample #1 after the edge, check the snapshot pulse
  // and pop the scoreboard when a snapshot is due.
  task automatic step(input logic en, input logic es, input logic mm,
                      input logic lat, input logic clr, input logic rs);
    snap_t e;
    logic  due;
    enable = en; err_state = es; err_mm = mm; latch = lat; clear = clr; rst = rs;
    @(posedge clk); #1;
    due = lat && !rs;
    chk("snap_valid", 64'(m_vld), 64'(due));
    chk("snap_valid_small", 64'(s_vld), 64'(due));
    if (due) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $error("FAIL snap_queue observed=empty expected=entry");
      end else begin
        e = q.pop_front();
        chk("snap_mm", 64'(m_mm), 64'(e.mm_m));
        chk("snap_mm_small", 64'(s_mm), 64'(e.mm_s));
        chk("snap_se", 64'(m_se), 64'(e.se));
        chk("snap_se_small", 64'(s_se), 64'(e.se));
        chk("snap_fe", 64'(m_fe), 64'(e.fe));
        chk("snap_fe_small", 64'(s_fe), 64'(e.fe));
      end
    end
  endtask

  task automatic chk_live(input string tag, input int st, input int seen,
                          input int ovf_m, input int ovf_s);
    chk({tag, "_state"}, 64'(m_st), 64'(st));
    chk({tag, "_state_small"}, 64'(s_st), 64'(st));
    chk({tag, "_seen"}, 64'(m_seen), 64'(seen));
    chk({tag, "_seen_small"}, 64'(s_seen), 64'(seen));
    chk({tag, "_ovf"}, 64'(m_ovf), 64'(ovf_m));
    chk({tag, "_ovf_small"}, 64'(s_ovf), 64'(ovf_s));
  endtask

  task automatic chk_zero(input string tag);
    chk_live(tag, 0, 0, 0, 0);
    chk({tag, "_mm"}, 64'(m_mm), 64'd0);
    chk({tag, "_se"}, 64'(m_se), 64'd0);
    chk({tag, "_fe"}, 64'(m_fe), 64'd0);
    chk({tag, "_mm_small"}, 64'(s_mm), 64'd0);
    chk({tag, "_fe_small"}, 64'(s_fe), 64'd0);
    chk({tag, "_vld"}, 64'(m_vld), 64'd0);
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_zero("reset");

    // Enable; idle for timestamps 0..2, mismatch at 3..7, then latch
    step(1, 0, 0, 0, 0, 0);
    chk_live("armed", 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk_live("first_mm", 2, 1, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0, 0);
    exp_snap(5, 5, 0, 3);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Clear, then error_state high 20, low 1, high 3
    step(1, 0, 0, 0, 1, 0);
    chk_live("clear1", 1, 0, 0, 0);
    repeat (20) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    exp_snap(0, 0, 2, 0);
    step(1, 0, 0, 1, 0, 0);
    chk_live("se_edges", 2, 1, 0, 0);

    // Saturation: 20 mismatches, small instance stops at 15
    step(1, 0, 0, 0, 1, 0);
    repeat (20) step(1, 0, 1, 0, 0, 0);
    exp_snap(20, 15, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk_live("sat", 2, 1, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    chk_live("sat_clear", 1, 0, 0, 0);

    // 7 mismatches, latch+clear together, latch again two cycles later
    repeat (7) step(1, 0, 1, 0, 0, 0);
    exp_snap(7, 7, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    chk_live("latch_clear", 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    exp_snap(0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);

    // Latch+clear with a mismatch in the same cycle: snapshot counts it
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    exp_snap(3, 3, 0, 2);
    step(1, 0, 1, 1, 1, 0);
    chk_live("latch_clear_ev", 1, 0, 0, 0);

    // Mismatch while disabled is ignored
    repeat (10) step(0, 0, 1, 0, 0, 0);
    chk_live("disabled", 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    exp_snap(0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk_live("reenable", 1, 0, 0, 0);

    // Mismatch coinciding with clear is discarded
    step(1, 0, 1, 0, 1, 0);
    chk_live("clear_ev", 1, 0, 0, 0);
    exp_snap(0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);

    // Error on record: disable then re-enable returns to ERRORED
    step(1, 0, 1, 0, 0, 0);
    chk_live("err_again", 2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_live("err_dis", 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk_live("err_reen", 2, 1, 0, 0);

    // Reset mid-run with a latch in the same cycle
    repeat (3) step(1, 0, 1, 0, 0, 0);
    exp_snap(4, 4, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0, 1);
    chk_zero("mid_reset");
    step(0, 0, 0, 0, 0, 0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
